// File: rtl/decrypt_sequencer_if.sv
// Header ingress, engine control/result and result-port signals of the decrypt sequencer.
// master = the sequencer itself; slave = the ingress, the three engines and the consumer.
interface decrypt_sequencer_if;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [127:0] hdr_in;

    logic         kd_start;
    logic [63:0]  kd_cipher;
    logic         kd_done;
    logic [15:0]  kd_m1;
    logic [15:0]  kd_m2;

    logic         rc_start;
    logic [31:0]  rc_ctxt;
    logic [31:0]  rc_key;
    logic         rc_done;
    logic [31:0]  rc_ptxt;

    logic         vf_start;
    logic [6:0]   vf_r;
    logic [6:0]   vf_s;
    logic         vf_done;
    logic [1:0]   vf_out;

    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_text;
    logic [1:0]   res_status;
    logic [1:0]   res_stage;
    logic         busy;

    modport master (
        input  hdr_valid, hdr_in, kd_done, kd_m1, kd_m2, rc_done, rc_ptxt,
               vf_done, vf_out, res_ready,
        output hdr_ready, kd_start, kd_cipher, rc_start, rc_ctxt, rc_key,
               vf_start, vf_r, vf_s, res_valid, res_text, res_status, res_stage, busy
    );

    modport slave (
        output hdr_valid, hdr_in, kd_done, kd_m1, kd_m2, rc_done, rc_ptxt,
               vf_done, vf_out, res_ready,
        input  hdr_ready, kd_start, kd_cipher, rc_start, rc_ctxt, rc_key,
               vf_start, vf_r, vf_s, res_valid, res_text, res_status, res_stage, busy
    );
endinterface

// File: rtl/decrypt_sequencer.sv
// Runs one encrypted header through key recovery, RC4 and signature verification,
// with a per-stage done timeout, and returns plaintext plus status on a valid/ready port.
module decrypt_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    decrypt_sequencer_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_KEY, S_RC4, S_VER, S_DONE} state_t;

    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [63:0]   kd_cipher_q, kd_cipher_d;
    logic [31:0]   rc_ctxt_q, rc_ctxt_d;
    logic [31:0]   rc_key_q, rc_key_d;
    logic [31:0]   ptxt_q, ptxt_d;
    logic [6:0]    vf_r_q, vf_r_d;
    logic [6:0]    vf_s_q, vf_s_d;
    logic          kd_start_q, kd_start_d;
    logic          rc_start_q, rc_start_d;
    logic          vf_start_q, vf_start_d;
    logic [31:0]   res_text_q, res_text_d;
    logic [1:0]    res_status_q, res_status_d;
    logic [1:0]    res_stage_q, res_stage_d;

    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{bus.hdr_in[127:101], bus.hdr_in[4:0]};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = '0;
        kd_cipher_d  = kd_cipher_q;
        rc_ctxt_d    = rc_ctxt_q;
        rc_key_d     = rc_key_q;
        ptxt_d       = ptxt_q;
        vf_r_d       = vf_r_q;
        vf_s_d       = vf_s_q;
        kd_start_d   = 1'b0;
        rc_start_d   = 1'b0;
        vf_start_d   = 1'b0;
        res_text_d   = res_text_q;
        res_status_d = res_status_q;
        res_stage_d  = res_stage_q;

        case (state_q)
            S_IDLE: begin
                if (bus.hdr_valid) begin
                    kd_cipher_d = bus.hdr_in[68:5];
                    rc_ctxt_d   = bus.hdr_in[100:69];
                    kd_start_d  = 1'b1;
                    state_d     = S_KEY;
                end
            end
            // In each wait state done is ignored while the start pulse is still high.
            S_KEY: begin
                cnt_d = cnt_q + 1'b1;
                if (!kd_start_q && bus.kd_done) begin
                    rc_key_d   = {bus.kd_m2, bus.kd_m1};
                    rc_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_RC4;
                end else if (cnt_q == TMO) begin
                    res_text_d   = '0;
                    res_status_d = 2'b10;
                    res_stage_d  = 2'b01;
                    cnt_d        = '0;
                    state_d      = S_DONE;
                end
            end
            S_RC4: begin
                cnt_d = cnt_q + 1'b1;
                if (!rc_start_q && bus.rc_done) begin
                    ptxt_d     = bus.rc_ptxt;
                    vf_r_d     = bus.rc_ptxt[6:0];
                    vf_s_d     = bus.rc_ptxt[13:7];
                    vf_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_VER;
                end else if (cnt_q == TMO) begin
                    res_text_d   = '0;
                    res_status_d = 2'b10;
                    res_stage_d  = 2'b10;
                    cnt_d        = '0;
                    state_d      = S_DONE;
                end
            end
            S_VER: begin
                cnt_d = cnt_q + 1'b1;
                if (!vf_start_q && bus.vf_done) begin
                    res_text_d   = ptxt_q;
                    res_status_d = (bus.vf_out == 2'b01) ? 2'b00 : 2'b01;
                    res_stage_d  = 2'b00;
                    cnt_d        = '0;
                    state_d      = S_DONE;
                end else if (cnt_q == TMO) begin
                    res_text_d   = '0;
                    res_status_d = 2'b10;
                    res_stage_d  = 2'b11;
                    cnt_d        = '0;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    res_text_d   = '0;
                    res_status_d = 2'b00;
                    res_stage_d  = 2'b00;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            kd_cipher_q  <= '0;
            rc_ctxt_q    <= '0;
            rc_key_q     <= '0;
            ptxt_q       <= '0;
            vf_r_q       <= '0;
            vf_s_q       <= '0;
            kd_start_q   <= 1'b0;
            rc_start_q   <= 1'b0;
            vf_start_q   <= 1'b0;
            res_text_q   <= '0;
            res_status_q <= '0;
            res_stage_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kd_cipher_q  <= kd_cipher_d;
            rc_ctxt_q    <= rc_ctxt_d;
            rc_key_q     <= rc_key_d;
            ptxt_q       <= ptxt_d;
            vf_r_q       <= vf_r_d;
            vf_s_q       <= vf_s_d;
            kd_start_q   <= kd_start_d;
            rc_start_q   <= rc_start_d;
            vf_start_q   <= vf_start_d;
            res_text_q   <= res_text_d;
            res_status_q <= res_status_d;
            res_stage_q  <= res_stage_d;
        end
    end

    assign bus.hdr_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.res_valid  = (state_q == S_DONE);
    assign bus.kd_start   = kd_start_q;
    assign bus.kd_cipher  = kd_cipher_q;
    assign bus.rc_start   = rc_start_q;
    assign bus.rc_ctxt    = rc_ctxt_q;
    assign bus.rc_key     = rc_key_q;
    assign bus.vf_start   = vf_start_q;
    assign bus.vf_r       = vf_r_q;
    assign bus.vf_s       = vf_s_q;
    assign bus.res_text   = res_text_q;
    assign bus.res_status = res_status_q;
    assign bus.res_stage  = res_stage_q;
endmodule

// File: tb/tb_decrypt_sequencer.sv
// Directed bench for decrypt_sequencer (TIMEOUT=8): nominal flow, signature fail,
// per-stage timeouts, done-at-TIMEOUT boundary, back-pressure and reset mid-RC4.
module tb_decrypt_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decrypt_sequencer_if bus ();

    decrypt_sequencer #(.TIMEOUT(8), .TW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Observations gathered by run_flow; cycle 1 is the cycle after the header handshake.
    int          kd_t, rc_t, vf_t, valid_t;
    int          kd_n, rc_n, vf_n;
    logic [63:0] kd_cipher_seen;
    logic [31:0] rc_ctxt_seen, rc_key_seen;
    logic [6:0]  vf_r_seen, vf_s_seen;

    logic [127:0] hdr_a, hdr_b;
    int           bad_cycles;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a header, then plays the three engines with the given latencies
    // (0 = never answers) until res_valid or a 60-cycle budget runs out.
    task automatic run_flow(input logic [127:0] hdr, input int kd_lat, input int rc_lat,
                            input int vf_lat, input logic [1:0] vf_val);
        kd_t = -1; rc_t = -1; vf_t = -1; valid_t = -1;
        kd_n = 0;  rc_n = 0;  vf_n = 0;
        bus.vf_out = vf_val;
        check("hdr_ready_before_offer", bus.hdr_ready, 1);
        bus.hdr_in    = hdr;
        bus.hdr_valid = 1'b1;
        step();
        bus.hdr_valid = 1'b0;
        for (int c = 1; c <= 60 && valid_t < 0; c++) begin
            if (bus.kd_start) begin
                kd_n++; kd_t = c;
                kd_cipher_seen = bus.kd_cipher;
                rc_ctxt_seen   = bus.rc_ctxt;
            end
            if (bus.rc_start) begin
                rc_n++; rc_t = c;
                rc_key_seen = bus.rc_key;
            end
            if (bus.vf_start) begin
                vf_n++; vf_t = c;
                vf_r_seen = bus.vf_r;
                vf_s_seen = bus.vf_s;
            end
            if (bus.res_valid) begin
                valid_t = c;
            end else begin
                bus.kd_done = (kd_t > 0 && kd_lat > 0 && c == kd_t + kd_lat);
                bus.rc_done = (rc_t > 0 && rc_lat > 0 && c == rc_t + rc_lat);
                bus.vf_done = (vf_t > 0 && vf_lat > 0 && c == vf_t + vf_lat);
                step();
            end
        end
        bus.kd_done = 1'b0;
        bus.rc_done = 1'b0;
        bus.vf_done = 1'b0;
        check("res_valid_within_budget", (valid_t > 0), 1);
    endtask

    task automatic take_result();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("post_take_res_valid", bus.res_valid, 0);
        check("post_take_hdr_ready", bus.hdr_ready, 1);
    endtask

    initial begin
        bus.hdr_valid = 1'b0;
        bus.hdr_in    = '0;
        bus.kd_done   = 1'b0;
        bus.kd_m1     = 16'h1111;
        bus.kd_m2     = 16'h2222;
        bus.rc_done   = 1'b0;
        bus.rc_ptxt   = 32'h0000_1A85;
        bus.vf_done   = 1'b0;
        bus.vf_out    = 2'b01;
        bus.res_ready = 1'b0;
        // Ignored header bits are non-zero so a wrong slice shows up.
        hdr_a = {27'h5A5_A5A5, 32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF, 5'h1F};
        hdr_b = {27'h0, 32'hCAFE_F00D, 64'hFEDC_BA98_7654_3210, 5'h00};

        // Reset state
        step();
        step();
        check("rst_hdr_ready", bus.hdr_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_starts", {bus.kd_start, bus.rc_start, bus.vf_start}, 0);
        check("rst_regs", {bus.rc_key, bus.res_text, bus.res_status, bus.res_stage}, 0);
        rst = 1'b0;
        step();

        // Nominal: key after 3, RC4 after 5, verify after 1, signature good
        run_flow(hdr_a, 3, 5, 1, 2'b01);
        check("nom_kd_cipher", kd_cipher_seen, 64'h0123_4567_89AB_CDEF);
        check("nom_rc_ctxt", rc_ctxt_seen, 32'hDEAD_BEEF);
        check("nom_rc_key", rc_key_seen, 32'h2222_1111);
        check("nom_vf_r", vf_r_seen, 7'h05);
        check("nom_vf_s", vf_s_seen, 7'h35);
        check("nom_pulse_counts", {kd_n[7:0], rc_n[7:0], vf_n[7:0]}, 24'h01_01_01);
        check("nom_start_times", {kd_t[7:0], rc_t[7:0], vf_t[7:0]}, {8'd1, 8'd5, 8'd11});
        check("nom_valid_cycle", valid_t, 13);
        check("nom_res_text", bus.res_text, 32'h0000_1A85);
        check("nom_status_stage", {bus.res_status, bus.res_stage}, 4'b00_00);
        check("nom_busy", bus.busy, 1);
        take_result();
        check("nom_idle_busy", bus.busy, 0);

        // Minimum latency: every engine answers one cycle after start
        run_flow(hdr_a, 1, 1, 1, 2'b01);
        check("min_latency", valid_t, 7);
        take_result();

        // Signature fail
        run_flow(hdr_a, 3, 5, 1, 2'b10);
        check("sig_status", bus.res_status, 2'b01);
        check("sig_res_text", bus.res_text, 32'h0000_1A85);
        check("sig_stage", bus.res_stage, 2'b00);
        take_result();

        // RC4 timeout: rc_start in cycle 3, counter hits 8 in cycle 11, DONE in cycle 12
        run_flow(hdr_a, 1, 0, 1, 2'b01);
        check("rto_rc_start", rc_t, 3);
        check("rto_valid_cycle", valid_t, 12);
        check("rto_status_stage", {bus.res_status, bus.res_stage}, 4'b10_10);
        check("rto_res_text", bus.res_text, 0);
        check("rto_no_vf_start", vf_n, 0);
        take_result();

        // Boundary: kd_done exactly when counter==TIMEOUT (cycle 9) is a success
        run_flow(hdr_a, 8, 1, 1, 2'b01);
        check("bnd_rc_start", rc_t, 10);
        check("bnd_valid_cycle", valid_t, 14);
        check("bnd_status_stage", {bus.res_status, bus.res_stage}, 4'b00_00);
        take_result();

        // One cycle later is a key timeout
        run_flow(hdr_a, 9, 1, 1, 2'b01);
        check("kto_valid_cycle", valid_t, 10);
        check("kto_status_stage", {bus.res_status, bus.res_stage}, 4'b10_01);
        check("kto_no_rc_start", rc_n, 0);
        take_result();

        // Verify timeout: plaintext is known but res_text must be zero
        run_flow(hdr_a, 1, 1, 0, 2'b01);
        check("vto_valid_cycle", valid_t, 14);
        check("vto_status_stage", {bus.res_status, bus.res_stage}, 4'b10_11);
        check("vto_res_text", bus.res_text, 0);
        take_result();

        // Back-pressure with a second header waiting
        run_flow(hdr_a, 1, 1, 1, 2'b01);
        bus.hdr_in    = hdr_b;
        bus.hdr_valid = 1'b1;
        bad_cycles    = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.res_valid !== 1'b1 || bus.res_text !== 32'h0000_1A85 ||
                bus.res_status !== 2'b00 || bus.res_stage !== 2'b00 ||
                bus.hdr_ready !== 1'b0 || bus.kd_start !== 1'b0)
                bad_cycles++;
        end
        check("bp_stable_cycles_bad", bad_cycles, 0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("bp_after_take_hdr_ready", bus.hdr_ready, 1);
        check("bp_after_take_kd_start", bus.kd_start, 0);
        step();
        bus.hdr_valid = 1'b0;
        check("bp_second_kd_start", bus.kd_start, 1);
        check("bp_second_cipher", bus.kd_cipher, 64'hFEDC_BA98_7654_3210);
        check("bp_second_hdr_ready", bus.hdr_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Done in the start cycle is ignored; then reset mid-RC4
        bus.hdr_in    = hdr_a;
        bus.hdr_valid = 1'b1;
        step();
        bus.hdr_valid = 1'b0;
        bus.kd_done   = 1'b1;
        step();
        check("same_cycle_done_ignored", bus.rc_start, 0);
        step();
        bus.kd_done = 1'b0;
        check("late_kd_done_taken", bus.rc_start, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_hdr_ready", bus.hdr_ready, 1);
        check("mid_rst_rc_key", bus.rc_key, 0);
        bus.rc_done = 1'b1;
        step();
        bus.rc_done = 1'b0;
        bad_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.res_valid !== 1'b0 || bus.vf_start !== 1'b0 || bus.busy !== 1'b0)
                bad_cycles++;
            step();
        end
        check("mid_rst_quiet_cycles_bad", bad_cycles, 0);
        check("mid_rst_final_hdr_ready", bus.hdr_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
